// File: rtl/pl_cpu_data_mem_if.sv
// Bus between the pipelined CPU's MEM stage / boot host and the data memory.
// Signal names follow the CPU top level so the two can be wired by name.
interface pl_cpu_data_mem_if #(
  parameter int ADDR_W = 8
);
  // CPU MEM-stage request and load data
  logic [31:0]       MEM_ADDRIN;
  logic [31:0]       MEM_WriteData;
  logic              MEM_MemRead;
  logic              MEM_MemWrite;
  logic [31:0]       MEM_ReadDataOUT;

  // Host preload stream
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              ld_last;

  modport master (
    output MEM_ADDRIN, MEM_WriteData, MEM_MemRead, MEM_MemWrite,
    output ld_valid, ld_addr, ld_data, ld_last,
    input  MEM_ReadDataOUT, ld_ready
  );

  modport slave (
    input  MEM_ADDRIN, MEM_WriteData, MEM_MemRead, MEM_MemWrite,
    input  ld_valid, ld_addr, ld_data, ld_last,
    output MEM_ReadDataOUT, ld_ready
  );
endinterface

// File: rtl/pl_cpu_data_mem.sv
// Data memory for the pipelined CPU: clears itself, accepts a host preload,
// then releases the CPU and serves word loads/stores with access statistics.
module pl_cpu_data_mem #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  pl_cpu_data_mem_if.slave bus,
  output logic             cpu_rst,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  output logic             err_addr
);
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [ADDR_W-1:0] clr_idx;
  logic              ld_ready_q;
  logic [31:0]       mem [DEPTH];

  logic              run;
  logic              addr_ok;
  logic [ADDR_W-1:0] cpu_idx;
  logic              rd_acc;
  logic              wr_acc;
  logic              bad_acc;
  logic              ld_acc;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_widx;
  logic [31:0]       mem_wdata;

  assign run     = (state == ST_RUN);
  assign cpu_idx = bus.MEM_ADDRIN[ADDR_W+1:2];
  // Word-aligned and inside the array; anything else is flagged, never aliased.
  assign addr_ok = (bus.MEM_ADDRIN[1:0] == 2'b00) && (bus.MEM_ADDRIN[31:ADDR_W+2] == '0);
  assign rd_acc  = run && bus.MEM_MemRead  && addr_ok;
  assign wr_acc  = run && bus.MEM_MemWrite && addr_ok;
  assign bad_acc = run && (bus.MEM_MemRead || bus.MEM_MemWrite) && !addr_ok;
  assign ld_acc  = (state == ST_LOAD) && bus.ld_valid && ld_ready_q;

  assign bus.ld_ready = ld_ready_q;
  // Loads see the array before this cycle's store lands, giving old data on load+store.
  assign bus.MEM_ReadDataOUT = rd_acc ? mem[cpu_idx] : 32'h0;

  // Single write port shared by clear, preload and CPU store; the state picks the source.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    mem_we    = 1'b0;
    mem_widx  = '0;
    mem_wdata = 32'h0;
    if (!rst) begin
      case (state)
        ST_CLEAR: begin
          mem_we    = 1'b1;
          mem_widx  = clr_idx;
        end
        ST_LOAD: begin
          mem_we    = ld_acc;
          mem_widx  = bus.ld_addr;
          mem_wdata = bus.ld_data;
        end
        ST_RUN: begin
          mem_we    = wr_acc;
          mem_widx  = cpu_idx;
          mem_wdata = bus.MEM_WriteData;
        end
        default: mem_we = 1'b0;
      endcase
    end
  end

  // NOTE: the array has no reset term; the CLEAR walk zeroes it, keeping it RAM-mappable.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  // NOTE: all sequential state is assigned non-blocking so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_CLEAR;
      clr_idx    <= '0;
      ld_ready_q <= 1'b0;
      cpu_rst    <= 1'b1;
      rd_count   <= '0;
      wr_count   <= '0;
      err_addr   <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_idx <= clr_idx + IDX_ONE;
          if (clr_idx == '1) begin
            state      <= ST_LOAD;
            ld_ready_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (ld_acc && bus.ld_last) begin
            state      <= ST_RUN;
            ld_ready_q <= 1'b0;
            cpu_rst    <= 1'b0;
          end
        end
        ST_RUN: begin
        end
        default: begin
          state      <= ST_CLEAR;
          clr_idx    <= '0;
          ld_ready_q <= 1'b0;
          cpu_rst    <= 1'b1;
        end
      endcase

      if (rd_acc && (rd_count != '1)) rd_count <= rd_count + CNT_ONE;
      if (wr_acc && (wr_count != '1)) wr_count <= wr_count + CNT_ONE;
      if (bad_acc) err_addr <= 1'b1;
    end
  end
endmodule
